// File: rtl/pulse_sequencer_if.sv
// Command/status bundle between a pulse-command source and pulse_sequencer.
// The master side offers commands and flush; the slave side is the sequencer.
interface pulse_sequencer_if #(
  parameter int LENGTH_WIDTH = 7,
  parameter int GAP_WIDTH    = 7,
  parameter int FIFO_DEPTH   = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                    cmd_valid;
  logic [LENGTH_WIDTH-1:0] cmd_length;
  logic [GAP_WIDTH-1:0]    cmd_gap;
  logic                    cmd_ready;
  logic                    flush;
  logic                    set_counter;
  logic [LENGTH_WIDTH-1:0] length_out;
  logic                    pulse_active;
  logic                    cmd_done;
  logic                    seq_busy;
  logic [CNT_W-1:0]        fifo_count;

  modport master (
    output cmd_valid, cmd_length, cmd_gap, flush,
    input  cmd_ready, set_counter, length_out, pulse_active, cmd_done,
           seq_busy, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_length, cmd_gap, flush,
    output cmd_ready, set_counter, length_out, pulse_active, cmd_done,
           seq_busy, fifo_count
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: queues {length, gap} commands and plays each one as a
// LOAD cycle, a pulse window of `length` cycles and an idle gap of `gap`
// cycles. Back-to-back commands run without an idle bubble; flush aborts the
// active command and empties the queue.
module pulse_sequencer #(
  parameter int LENGTH_WIDTH = 7,
  parameter int GAP_WIDTH    = 7,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             clk,
  input logic             rst,
  pulse_sequencer_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = LENGTH_WIDTH + GAP_WIDTH;
  localparam logic [CNT_W-1:0]        DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]    GAP_ONE = GAP_WIDTH'(1);
  localparam logic [PTR_W-1:0]        PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_fsm_next;
  state_t                  w_next_state;
  logic [ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [LENGTH_WIDTH-1:0] r_pulse_cnt;
  logic [GAP_WIDTH-1:0]    r_gap_cnt;
  logic [LENGTH_WIDTH-1:0] r_length_out;
  logic [LENGTH_WIDTH-1:0] w_head_len;
  logic [GAP_WIDTH-1:0]    w_head_gap;
  logic                    w_cmd_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_set_counter;
  logic                    w_pulse_active;
  logic                    w_cmd_done;

  assign {w_head_len, w_head_gap} = r_mem[r_rd_ptr];

  // No bypass: a full queue refuses even when the head is popped this cycle.
  assign w_cmd_ready = (r_count < DEPTH_C) & ~bus.flush;
  assign w_push      = bus.cmd_valid & w_cmd_ready;
  assign w_pop       = (r_state == S_LOAD) & ~bus.flush;

  // Command storage: write the accepted command at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_length, bus.cmd_gap};
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Pulse and gap down-counters: loaded in LOAD, decremented in their phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse_cnt <= '0;
      r_gap_cnt   <= '0;
    end else if (bus.flush) begin
      r_pulse_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_pulse_cnt <= w_head_len;
          r_gap_cnt   <= w_head_gap;
        end
        S_PULSE: begin
          if (r_pulse_cnt != '0) begin
            r_pulse_cnt <= r_pulse_cnt - LEN_ONE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        default: begin
          r_pulse_cnt <= r_pulse_cnt;
          r_gap_cnt   <= r_gap_cnt;
        end
      endcase
    end
  end

  // Remember the last loaded length so length_out holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_length_out <= '0;
    end else if (r_state == S_LOAD) begin
      r_length_out <= w_head_len;
    end else begin
      r_length_out <= r_length_out;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state strobes. A command completing in its own LOAD
  // cycle compares against the occupancy minus the entry being popped.
  always_comb begin
    w_fsm_next     = r_state;
    w_set_counter  = 1'b0;
    w_pulse_active = 1'b0;
    w_cmd_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_fsm_next = S_LOAD;
        end else begin
          w_fsm_next = S_IDLE;
        end
      end
      S_LOAD: begin
        w_set_counter = 1'b1;
        if (w_head_len != '0) begin
          w_fsm_next = S_PULSE;
        end else if (w_head_gap != '0) begin
          w_fsm_next = S_GAP;
        end else begin
          w_cmd_done = 1'b1;
          w_fsm_next = (r_count > CNT_ONE) ? S_LOAD : S_IDLE;
        end
      end
      S_PULSE: begin
        w_pulse_active = 1'b1;
        if (r_pulse_cnt > LEN_ONE) begin
          w_fsm_next = S_PULSE;
        end else if (r_gap_cnt != '0) begin
          w_fsm_next = S_GAP;
        end else begin
          w_cmd_done = 1'b1;
          w_fsm_next = (r_count != '0) ? S_LOAD : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt > GAP_ONE) begin
          w_fsm_next = S_GAP;
        end else begin
          w_cmd_done = 1'b1;
          w_fsm_next = (r_count != '0) ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase
    if (bus.flush) begin
      w_next_state = S_IDLE;
    end else begin
      w_next_state = w_fsm_next;
    end
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.set_counter  = w_set_counter;
  assign bus.length_out   = (r_state == S_LOAD) ? w_head_len : r_length_out;
  assign bus.pulse_active = w_pulse_active;
  assign bus.cmd_done     = w_cmd_done;
  assign bus.seq_busy     = (r_state != S_IDLE);
  assign bus.fifo_count   = r_count;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer. Accepted commands go into an
// expected queue; every cycle the monitor pops on each LOAD and checks
// length_out, the pulse window, cmd_done timing and seq_busy.
module tb_pulse_sequencer;
  localparam int LW    = 7;
  localparam int GW    = 7;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [GW-1:0] gap;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_sequencer_if #(.LENGTH_WIDTH(LW), .GAP_WIDTH(GW), .FIFO_DEPTH(DEPTH)) bus ();

  pulse_sequencer #(.LENGTH_WIDTH(LW), .GAP_WIDTH(GW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  cmd_t exp_q[$];
  int   load_cycs[$];
  int   done_cycs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;
  bit   in_cmd = 1'b0;
  int   pos, cur_l, cur_g;
  bit   last_accept;

  task automatic monitor();
    cmd_t e;
    bit exp_pa, exp_done;
    if (bus.set_counter === 1'b1) begin
      load_cycs.push_back(cyc);
      checks++;
      if (in_cmd) begin errors++; $display("FAIL sb_overlap cyc %0d: load while command pos %0d active", cyc, pos); end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_load cyc %0d: LOAD seen, expected none", cyc);
        in_cmd = 1'b0;
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.length_out !== e.len) begin errors++; $display("FAIL sb_length cyc %0d: got %0d expected %0d", cyc, bus.length_out, e.len); end
        cur_l = int'(e.len); cur_g = int'(e.gap); pos = 1; in_cmd = 1'b1;
      end
    end else if (in_cmd) begin
      pos++;
    end
    if (in_cmd) begin
      exp_pa   = (pos >= 2) && (pos <= cur_l + 1);
      exp_done = (pos == 1 + cur_l + cur_g);
      checks++;
      if (bus.pulse_active !== exp_pa) begin errors++; $display("FAIL sb_pulse cyc %0d pos %0d: got %b expected %b", cyc, pos, bus.pulse_active, exp_pa); end
      checks++;
      if (bus.cmd_done !== exp_done) begin errors++; $display("FAIL sb_done cyc %0d pos %0d: got %b expected %b", cyc, pos, bus.cmd_done, exp_done); end
      checks++;
      if (bus.seq_busy !== 1'b1) begin errors++; $display("FAIL sb_busy cyc %0d: got %b expected 1", cyc, bus.seq_busy); end
      if (exp_done) begin in_cmd = 1'b0; done_cycs.push_back(cyc); n_done++; end
    end else begin
      checks++;
      if (bus.pulse_active !== 1'b0 || bus.cmd_done !== 1'b0) begin
        errors++; $display("FAIL sb_idle cyc %0d: pulse_active %b cmd_done %b expected 0 0", cyc, bus.pulse_active, bus.cmd_done);
      end
    end
  endtask

  // One clock: note the handshake before the edge, then sample at negedge.
  task automatic cycle();
    cmd_t e;
    #1;
    last_accept = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1) && (rst === 1'b0);
    e.len = bus.cmd_length;
    e.gap = bus.cmd_gap;
    @(posedge clk);
    if (last_accept) exp_q.push_back(e);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic offer(input int len, input int gap);
    bus.cmd_valid  = 1'b1;
    bus.cmd_length = LW'(len);
    bus.cmd_gap    = GW'(gap);
    cycle();
  endtask

  task automatic push_hold(input int len, input int gap, input int budget);
    int n = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_length = LW'(len);
    bus.cmd_gap    = GW'(gap);
    last_accept    = 1'b0;
    while (!last_accept && n < budget) begin cycle(); n++; end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!last_accept) begin errors++; $display("FAIL push_timeout: accepted 0 expected 1 within %0d cycles", budget); end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    bus.cmd_valid = 1'b0;
    while ((in_cmd || exp_q.size() != 0 || bus.seq_busy !== 1'b0) && n < budget) begin cycle(); n++; end
    checks++;
    if (in_cmd || exp_q.size() != 0 || bus.seq_busy !== 1'b0) begin
      errors++; $display("FAIL %s_timeout: busy %b pending %0d expected idle", name, bus.seq_busy, exp_q.size());
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    in_cmd = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.set_counter !== 1'b0 || bus.pulse_active !== 1'b0 || bus.cmd_done !== 1'b0 || bus.seq_busy !== 1'b0) begin
      errors++; $display("FAIL %s_strobes: set %b pulse %b done %b busy %b expected 0 0 0 0", name, bus.set_counter, bus.pulse_active, bus.cmd_done, bus.seq_busy);
    end
    checks++;
    if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL %s_count: got %0d expected 0", name, bus.fifo_count); end
    checks++;
    if (bus.length_out !== 7'd0) begin errors++; $display("FAIL %s_length: got %0d expected 0", name, bus.length_out); end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.flush = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_length = '0; bus.cmd_gap = '0;
    cycle(); cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_single();
    offer(3, 2);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd1 || bus.seq_busy !== 1'b0) begin
      errors++; $display("FAIL single_c1: count %0d busy %b expected 1 0", bus.fifo_count, bus.seq_busy);
    end
    for (int c = 2; c <= 8; c++) begin
      cycle();
      checks++;
      if (bus.set_counter !== (c == 2) || bus.pulse_active !== (c >= 3 && c <= 5) ||
          bus.cmd_done !== (c == 7) || bus.seq_busy !== (c <= 7)) begin
        errors++; $display("FAIL single_c%0d: set %b pulse %b done %b busy %b expected %b %b %b %b", c,
          bus.set_counter, bus.pulse_active, bus.cmd_done, bus.seq_busy, c == 2, c >= 3 && c <= 5, c == 7, c <= 7);
      end
      if (c == 2) begin
        checks++;
        if (bus.length_out !== 7'd3) begin errors++; $display("FAIL single_length: got %0d expected 3", bus.length_out); end
      end
    end
    checks++;
    if (bus.length_out !== 7'd3) begin errors++; $display("FAIL single_hold: got %0d expected 3", bus.length_out); end
  endtask

  task automatic test_back_to_back();
    load_cycs.delete(); done_cycs.delete();
    offer(4, 0);
    offer(2, 1);
    wait_idle(40, "b2b");
    checks++;
    if (load_cycs.size() != 2 || done_cycs.size() != 2) begin
      errors++; $display("FAIL b2b_count: loads %0d dones %0d expected 2 2", load_cycs.size(), done_cycs.size());
    end else begin
      checks++;
      if (load_cycs[1] != done_cycs[0] + 1) begin errors++; $display("FAIL b2b_bubble: second load cyc %0d expected %0d", load_cycs[1], done_cycs[0] + 1); end
      checks++;
      if (done_cycs[0] - load_cycs[0] != 4 || done_cycs[1] - load_cycs[1] != 3) begin
        errors++; $display("FAIL b2b_dur: %0d %0d expected 4 3", done_cycs[0] - load_cycs[0], done_cycs[1] - load_cycs[1]);
      end
    end
  endtask

  task automatic test_zero();
    load_cycs.delete(); done_cycs.delete();
    offer(0, 0);
    offer(0, 3);
    wait_idle(40, "zero");
    checks++;
    if (load_cycs.size() != 2 || done_cycs.size() != 2) begin
      errors++; $display("FAIL zero_count: loads %0d dones %0d expected 2 2", load_cycs.size(), done_cycs.size());
    end else begin
      checks++;
      if (done_cycs[0] != load_cycs[0] || load_cycs[1] != load_cycs[0] + 1 || done_cycs[1] != load_cycs[1] + 3) begin
        errors++; $display("FAIL zero_timing: loads %0d %0d dones %0d %0d expected done0=load0, load1=load0+1, done1=load1+3",
          load_cycs[0], load_cycs[1], done_cycs[0], done_cycs[1]);
      end
    end
    load_cycs.delete();
    offer(0, 0);
    wait_idle(20, "zero_lone");
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (load_cycs.size() != 1) begin errors++; $display("FAIL zero_lone: loads %0d expected 1", load_cycs.size()); end
  endtask

  task automatic test_full_wrap();
    int  n0 = n_done;
    int  n = 0;
    bit  acc = 1'b0;
    bit  saw_pop_full = 1'b0;
    offer(6, 2); offer(1, 1); offer(2, 0); offer(0, 2); offer(3, 1);
    checks++;
    if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.fifo_count); end
    bus.cmd_valid = 1'b1; bus.cmd_length = 7'd1; bus.cmd_gap = 7'd2;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.cmd_ready); end
    while (!acc && n < 60) begin
      cycle(); n++;
      acc = last_accept;
      if (!acc && bus.fifo_count === 3'd4) begin
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold cyc %0d: ready %b expected 0", cyc, bus.cmd_ready); end
        if (bus.set_counter === 1'b1) saw_pop_full = 1'b1;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!acc || !saw_pop_full) begin errors++; $display("FAIL full_release: accepted %b pop_while_full %b expected 1 1", acc, saw_pop_full); end
    for (int i = 0; i < 6; i++) push_hold($urandom_range(0, 3), $urandom_range(0, 3), 60);
    wait_idle(200, "wrap");
    checks++;
    if (n_done != n0 + 12) begin errors++; $display("FAIL wrap_done: got %0d expected %0d", n_done - n0, 12); end
  endtask

  task automatic test_flush();
    int n0;
    offer(5, 5); offer(1, 1); offer(2, 2);
    bus.cmd_valid = 1'b0;
    cycle();
    n0 = n_done;
    checks++;
    if (bus.pulse_active !== 1'b1 || bus.fifo_count !== 3'd2) begin
      errors++; $display("FAIL flush_pre: pulse %b count %0d expected 1 2", bus.pulse_active, bus.fifo_count);
    end
    bus.flush = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_length = 7'd7; bus.cmd_gap = 7'd7;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.cmd_ready); end
    clear_sb();
    cycle();
    bus.flush = 1'b0; bus.cmd_valid = 1'b0;
    checks++;
    if (bus.seq_busy !== 1'b0 || bus.fifo_count !== 3'd0 || bus.pulse_active !== 1'b0 || bus.cmd_done !== 1'b0) begin
      errors++; $display("FAIL flush_post: busy %b count %0d pulse %b done %b expected 0 0 0 0", bus.seq_busy, bus.fifo_count, bus.pulse_active, bus.cmd_done);
    end
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (n_done != n0 || bus.seq_busy !== 1'b0) begin errors++; $display("FAIL flush_quiet: dones %0d busy %b expected 0 0", n_done - n0, bus.seq_busy); end
    offer(2, 1);
    wait_idle(30, "flush_recover");
    checks++;
    if (n_done != n0 + 1) begin errors++; $display("FAIL flush_recover: dones %0d expected 1", n_done - n0); end
  endtask

  task automatic test_reset_mid();
    offer(2, 6); offer(1, 0); offer(1, 1); offer(2, 2); offer(3, 3);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd4 || bus.seq_busy !== 1'b1 || bus.pulse_active !== 1'b0) begin
      errors++; $display("FAIL rstmid_pre: count %0d busy %b pulse %b expected 4 1 0", bus.fifo_count, bus.seq_busy, bus.pulse_active);
    end
    cycle();
    rst = 1'b1; bus.flush = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_length = 7'd5; bus.cmd_gap = 7'd5;
    clear_sb();
    cycle();
    check_reset_outputs("rstmid");
    rst = 1'b0; bus.flush = 1'b0; bus.cmd_valid = 1'b0;
    cycle();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.seq_busy !== 1'b0 || bus.fifo_count !== 3'd0) begin
      errors++; $display("FAIL rstmid_release: ready %b busy %b count %0d expected 1 0 0", bus.cmd_ready, bus.seq_busy, bus.fifo_count);
    end
    offer(1, 1);
    wait_idle(20, "rstmid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_full_wrap();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
